// File: rtl/commit_pc2_packer.sv
// rtl/commit_pc2_packer.sv - packs the in-order retire stream into dual-slot commit reports
// Slot 1 always carries the older PC; a lone PC leaves on flush or after TIMEOUT cycles.
module commit_pc2_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_pc,
  input  logic                     flush,
  output logic                     wen1,
  output logic [DATA_WIDTH-1:0]    pc1,
  output logic                     wen2,
  output logic [DATA_WIDTH-1:0]    pc2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_nxt;
  logic [TW-1:0]         timer;

  logic                  push;
  logic                  emit_pair;
  logic                  emit_single;
  logic [CW-1:0]         pop_n;
  logic [CW-1:0]         count_next;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] head_nxt;

  assign in_ready = (count < CW'(DEPTH));

  // Emission looks only at registered count, so a PC pushed this cycle waits one more.
  always_comb begin
    push        = in_valid && in_ready;
    emit_pair   = (count >= CW'(2));
    emit_single = (count == CW'(1)) && (flush || (timer == TMAX));
    pop_n       = emit_pair ? CW'(2) : (emit_single ? CW'(1) : CW'(0));
    count_next  = count + CW'(push) - pop_n;
    rd_nxt      = rd_ptr + AW'(1);
    head        = mem[rd_ptr];
    head_nxt    = mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr] <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      timer  <= '0;
      wen1   <= 1'b0;
      wen2   <= 1'b0;
      pc1    <= '0;
      pc2    <= '0;
    end else begin
      count  <= count_next;
      rd_ptr <= rd_ptr + pop_n[AW-1:0];
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      if ((count != CW'(1)) || emit_pair || emit_single) begin
        timer <= '0;
      end else if (timer != TMAX) begin
        timer <= timer + TW'(1);
      end

      wen1 <= emit_pair || emit_single;
      wen2 <= emit_pair;
      if (emit_pair || emit_single) begin
        pc1 <= head;
      end
      pc2 <= emit_pair ? head_nxt : '0;
    end
  end

endmodule

// File: doc/commit_pc2_packer.md
Name: commit_pc2_packer

Overview:
- Sits on the core's commit stage. Accepts the in-order retire stream, one PC per handshake.
- Packs retired PCs into the dual-slot commit report consumed by the two-PC simulator reporter (wen1/pc1/wen2/pc2).
- Slot 1 is always the older instruction. A lone PC is released after a timeout or on flush, so it never starves.
- Drives the existing dual-PC reporter directly; no reformatting is needed in between.

Parameters:
- DATA_WIDTH, 32, PC width.
- DEPTH, 8, buffer entries; power of two, at least 4.
- TIMEOUT, 4, cycles a single buffered PC may wait before it is emitted alone; at least 1.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous active-low reset: rst=0 at a posedge resets the block.
- in_valid  input  1  retire stream valid.
- in_ready  output  1  buffer can accept; combinational, equals (count < DEPTH).
- in_pc  input  DATA_WIDTH  retired PC.
- flush  input  1  force emission of a lone buffered PC (pipeline flush, halt, end of sim).
- wen1  output  1  slot-1 report valid, registered.
- pc1  output  DATA_WIDTH  slot-1 PC (older), registered.
- wen2  output  1  slot-2 report valid, registered.
- pc2  output  DATA_WIDTH  slot-2 PC (younger), registered; 0 whenever wen2=0.
- count  output  $clog2(DEPTH)+1  current occupancy, for debug and verification.

Behaviour:
- Reset (rst=0 at posedge): count, read/write pointers, timer, wen1, wen2, pc1 and pc2 all go to 0.
  - Buffered entries are discarded.
  - The cycle after reset shows no report.
  - Reset overrides push, pop and flush in the same cycle.
- Storage is a circular FIFO with read/write pointers that wrap modulo DEPTH.
- Push occurs when in_valid && in_ready. in_ready ignores same-cycle pops, so a full buffer refuses input even while draining.
- Emission is decided each cycle from registered count (a same-cycle push is never considered):
  - count >= 2: emit a pair. The head goes to pc1/wen1=1, head+1 goes to pc2/wen2=1; pop 2.
  - count == 1 and (flush || timer == TIMEOUT-1): emit single. The head goes to pc1/wen1=1, wen2=0, pc2=0; pop 1.
  - Otherwise: wen1=0, wen2=0. pc1 holds its last value; pc2 is 0.
- Outputs are registered. A decision made in cycle N appears in cycle N+1.
- Minimum latency: a PC pushed in cycle N is counted at N+1 and reported at N+2.
- count_next = count + push − pop. Push and pop in the same cycle are legal, including at count == DEPTH−1 and count == 2.
- Timer:
  - Increments each cycle count==1 and no emission occurs.
  - Clears to 0 when count != 1 or on any emission.
  - Saturates at TIMEOUT−1.
- Invariants:
  - wen2=1 implies wen1=1.
  - The report order across cycles equals push order; no PC is dropped or duplicated.
  - Within a cycle, pc1 is older than pc2.
- flush with count==0 has no effect. flush with count>=2 follows the pair rule; an odd leftover waits for the next flush or the timeout.

Test Plan:
- Back-to-back push 0x80000000, 0x80000004, 0x80000008, 0x8000000C on consecutive cycles.
  -> Pair reports {wen1=1 pc1=0x80000000, wen2=1 pc2=0x80000004}, then {0x80000008, 0x8000000C}, with no singles.
- Push only 0x1000, TIMEOUT=4, no flush.
  -> wen1=0 for the timeout window, then exactly one report wen1=1 pc1=0x1000 wen2=0 pc2=0. Count returns to 0.
- Push 0x2000, then assert flush on the next cycle.
  -> The cycle after flush shows wen1=1 pc1=0x2000 wen2=0, without waiting for the timeout.
- Hold in_valid=1 with incrementing PCs from reset.
  -> Count never exceeds DEPTH=8 and in_ready=0 only at count=8. The reported sequence equals the pushed sequence across at least 3 pointer wraps.
- Fill to count=5, then rst=0 for one cycle, then push 0x3000 and 0x3004.
  -> Zero reports while in reset and the cycle after. The next report is {0x3000, 0x3004}; none of the pre-reset PCs appear.
- Randomised valid with flush pulses, checked by a scoreboard.
  -> wen2 never 1 while wen1=0, order preserved, and every pushed PC reported exactly once.
